// File: rtl/exu_cp0_seq.sv
// CP0 CSR sequencer: runs one CSRRW/CSRRS/CSRRC op through CSR/PRF read, execute and writeback.
// Latency: wb 3 cycles after accept with EXU_CP0_SEQ_SERIALIZE_EN (waits to be oldest), else 2.
// Backpressure: none; ops offered while cp0_seq_busy is high are dropped, the issuer must hold off.
module exu_cp0_seq (
    input  logic        clk,
    input  logic        rst_clk,
    input  logic        rtu_global_flush,
    input  logic        cp0_vld,
    input  logic [4:0]  cp0_iid,
    input  logic [6:0]  cp0_opcode,
    input  logic        cp0_psrc1_vld,
    input  logic [5:0]  cp0_psrc1,
    input  logic        cp0_imm_vld,
    input  logic [63:0] cp0_imm,
    input  logic [4:0]  rtu_cp0_oldest_iid,
    output logic        cp0_prf_rd_vld,
    output logic [5:0]  cp0_prf_rd_preg,
    input  logic [63:0] prf_cp0_rdata,
    output logic        cp0_csr_rd_vld,
    output logic [11:0] cp0_csr_addr,
    input  logic [63:0] csr_cp0_rdata,
    output logic        cp0_csr_wr_vld,
    output logic [63:0] cp0_csr_wdata,
    output logic        cp0_wb_vld,
    output logic [4:0]  cp0_wb_iid,
    output logic [63:0] cp0_wb_data,
    output logic        cp0_wb_exc,
    output logic        cp0_seq_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] EXE  = 2'd3;

    localparam logic [6:0] OP_CSRRW = 7'h01;
    localparam logic [6:0] OP_CSRRS = 7'h02;
    localparam logic [6:0] OP_CSRRC = 7'h03;

`ifdef EXU_CP0_SEQ_SERIALIZE_EN
    localparam logic [1:0] FIRST = WAIT;
`else
    localparam logic [1:0] FIRST = RD;
`endif

    logic [1:0]  state;
    logic [4:0]  iid_q;
    logic [6:0]  opcode_q;
    logic        psrc1_vld_q;
    logic [5:0]  psrc1_q;
    logic [16:0] imm_q;

    logic        live;
    logic        legal;
    logic        set_or_clr;
    logic [63:0] operand;
    logic [63:0] wdata;

    // Only imm[16:0] carries meaning (CSR address and 5-bit immediate operand).
`ifdef EXU_CP0_SEQ_SERIALIZE_EN
    logic unused_in;
    assign unused_in = ^{cp0_imm_vld, cp0_imm[63:17]};
`else
    logic unused_in;
    assign unused_in = ^{cp0_imm_vld, cp0_imm[63:17], rtu_cp0_oldest_iid};
`endif

    always_ff @(posedge clk) begin
        if (!rst_clk) begin
            state       <= IDLE;
            iid_q       <= 5'd0;
            opcode_q    <= 7'd0;
            psrc1_vld_q <= 1'b0;
            psrc1_q     <= 6'd0;
            imm_q       <= 17'd0;
        end else if (rtu_global_flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cp0_vld) begin
                        iid_q       <= cp0_iid;
                        opcode_q    <= cp0_opcode;
                        psrc1_vld_q <= cp0_psrc1_vld;
                        psrc1_q     <= cp0_psrc1;
                        imm_q       <= cp0_imm[16:0];
                        state       <= FIRST;
                    end
                end
`ifdef EXU_CP0_SEQ_SERIALIZE_EN
                WAIT: begin
                    if (rtu_cp0_oldest_iid == iid_q) begin
                        state <= RD;
                    end
                end
`endif
                RD:      state <= EXE;
                EXE:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign live       = rst_clk & ~rtu_global_flush;
    assign legal      = (opcode_q == OP_CSRRW) | (opcode_q == OP_CSRRS) | (opcode_q == OP_CSRRC);
    assign set_or_clr = (opcode_q == OP_CSRRS) | (opcode_q == OP_CSRRC);
    assign operand    = psrc1_vld_q ? prf_cp0_rdata : {59'd0, imm_q[16:12]};

    always_comb begin
        wdata = 64'd0;
        case (opcode_q)
            OP_CSRRW: wdata = operand;
            OP_CSRRS: wdata = csr_cp0_rdata | operand;
            OP_CSRRC: wdata = csr_cp0_rdata & ~operand;
            default:  wdata = 64'd0;
        endcase
    end

    // Set/clear with a zero operand reads the CSR but must not write it.
    assign cp0_csr_rd_vld  = live & (state == RD) & legal;
    assign cp0_prf_rd_vld  = live & (state == RD) & legal & psrc1_vld_q;
    assign cp0_csr_wr_vld  = live & (state == EXE) & legal & ~(set_or_clr & (operand == 64'd0));
    assign cp0_wb_vld      = live & (state == EXE);

    assign cp0_prf_rd_preg = cp0_prf_rd_vld ? psrc1_q : 6'd0;
    assign cp0_csr_addr    = (cp0_csr_rd_vld | cp0_csr_wr_vld) ? imm_q[11:0] : 12'd0;
    assign cp0_csr_wdata   = cp0_csr_wr_vld ? wdata : 64'd0;
    assign cp0_wb_iid      = cp0_wb_vld ? iid_q : 5'd0;
    assign cp0_wb_data     = (cp0_wb_vld & legal) ? csr_cp0_rdata : 64'd0;
    assign cp0_wb_exc      = cp0_wb_vld & ~legal;
    assign cp0_seq_busy    = rst_clk & (state != IDLE);

endmodule

// File: tb/tb_exu_cp0_seq.sv
// Directed bench for exu_cp0_seq: per-op expected writebacks/CSR writes are queued at issue and checked as they appear.
module tb_exu_cp0_seq;

    logic        clk;
    logic        rst_clk;
    logic        rtu_global_flush;
    logic        cp0_vld;
    logic [4:0]  cp0_iid;
    logic [6:0]  cp0_opcode;
    logic        cp0_psrc1_vld;
    logic [5:0]  cp0_psrc1;
    logic        cp0_imm_vld;
    logic [63:0] cp0_imm;
    logic [4:0]  rtu_cp0_oldest_iid;
    logic        cp0_prf_rd_vld;
    logic [5:0]  cp0_prf_rd_preg;
    logic [63:0] prf_cp0_rdata;
    logic        cp0_csr_rd_vld;
    logic [11:0] cp0_csr_addr;
    logic [63:0] csr_cp0_rdata;
    logic        cp0_csr_wr_vld;
    logic [63:0] cp0_csr_wdata;
    logic        cp0_wb_vld;
    logic [4:0]  cp0_wb_iid;
    logic [63:0] cp0_wb_data;
    logic        cp0_wb_exc;
    logic        cp0_seq_busy;

    exu_cp0_seq dut (
        .clk                (clk),
        .rst_clk            (rst_clk),
        .rtu_global_flush   (rtu_global_flush),
        .cp0_vld            (cp0_vld),
        .cp0_iid            (cp0_iid),
        .cp0_opcode         (cp0_opcode),
        .cp0_psrc1_vld      (cp0_psrc1_vld),
        .cp0_psrc1          (cp0_psrc1),
        .cp0_imm_vld        (cp0_imm_vld),
        .cp0_imm            (cp0_imm),
        .rtu_cp0_oldest_iid (rtu_cp0_oldest_iid),
        .cp0_prf_rd_vld     (cp0_prf_rd_vld),
        .cp0_prf_rd_preg    (cp0_prf_rd_preg),
        .prf_cp0_rdata      (prf_cp0_rdata),
        .cp0_csr_rd_vld     (cp0_csr_rd_vld),
        .cp0_csr_addr       (cp0_csr_addr),
        .csr_cp0_rdata      (csr_cp0_rdata),
        .cp0_csr_wr_vld     (cp0_csr_wr_vld),
        .cp0_csr_wdata      (cp0_csr_wdata),
        .cp0_wb_vld         (cp0_wb_vld),
        .cp0_wb_iid         (cp0_wb_iid),
        .cp0_wb_data        (cp0_wb_data),
        .cp0_wb_exc         (cp0_wb_exc),
        .cp0_seq_busy       (cp0_seq_busy)
    );

    localparam logic [63:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

    typedef struct { logic [4:0] iid; logic [63:0] data; logic exc; int lat; } wb_exp_t;
    typedef struct { logic [63:0] wdata; logic [11:0] addr; int lat; } wr_exp_t;

    wb_exp_t wb_q[$];
    wr_exp_t wr_q[$];

    int n_chk;
    int n_pass;
    logic [63:0] prf_val;
    logic [63:0] csr_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PRF/CSR return data one cycle after a read; unrequested cycles return junk.
    always @(posedge clk) begin
        prf_cp0_rdata <= cp0_prf_rd_vld ? prf_val : GARBAGE;
        csr_cp0_rdata <= cp0_csr_rd_vld ? csr_val : GARBAGE;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic junk_on_invalid();
        return (!cp0_prf_rd_vld && cp0_prf_rd_preg != 6'd0) ||
               (!cp0_csr_rd_vld && !cp0_csr_wr_vld && cp0_csr_addr != 12'd0) ||
               (!cp0_csr_wr_vld && cp0_csr_wdata != 64'd0) ||
               (!cp0_wb_vld && (cp0_wb_iid != 5'd0 || cp0_wb_data != 64'd0 || cp0_wb_exc));
    endfunction

    function automatic logic any_output();
        return |{cp0_prf_rd_vld, cp0_prf_rd_preg, cp0_csr_rd_vld, cp0_csr_addr, cp0_csr_wr_vld,
                 cp0_csr_wdata, cp0_wb_vld, cp0_wb_iid, cp0_wb_data, cp0_wb_exc, cp0_seq_busy};
    endfunction

    function automatic logic any_pulse();
        return cp0_prf_rd_vld | cp0_csr_rd_vld | cp0_csr_wr_vld | cp0_wb_vld;
    endfunction

    task automatic run_op(input string tag, input logic [4:0] iid, input logic [6:0] opc,
                          input logic p1v, input logic [5:0] p1, input logic [63:0] imm,
                          input logic [63:0] prf, input logic [63:0] csr, input int match_off,
                          input bit hold_vld, input bit exp_wr, input logic [63:0] exp_wdata,
                          input logic [63:0] exp_wbdata, input logic exp_exc);
        int lat;
        int n_rd;
        int n_prf;
        int n_wr;
        int n_wb;
        wb_exp_t wbe;
        wr_exp_t wre;
`ifdef EXU_CP0_SEQ_SERIALIZE_EN
        lat = match_off + 2;
`else
        lat = 2;
`endif
        n_rd = 0; n_prf = 0; n_wr = 0; n_wb = 0;
        wbe.iid = iid; wbe.data = exp_wbdata; wbe.exc = exp_exc; wbe.lat = lat;
        wb_q.push_back(wbe);
        if (exp_wr) begin
            wre.wdata = exp_wdata; wre.addr = imm[11:0]; wre.lat = lat;
            wr_q.push_back(wre);
        end
        prf_val = prf;
        csr_val = csr;
        for (int off = 0; off <= lat + 2; off++) begin
            @(posedge clk); #1;
            if (off == 0) begin
                cp0_vld = 1'b1; cp0_iid = iid; cp0_opcode = opc; cp0_psrc1_vld = p1v;
                cp0_psrc1 = p1; cp0_imm_vld = 1'b1; cp0_imm = imm;
            end else if (hold_vld && off <= lat) begin
                cp0_vld = 1'b1; cp0_iid = ~iid; cp0_opcode = 7'h01; cp0_psrc1_vld = ~p1v;
                cp0_psrc1 = ~p1; cp0_imm = ~imm;
            end else begin
                cp0_vld = 1'b0;
            end
`ifdef EXU_CP0_SEQ_SERIALIZE_EN
            rtu_cp0_oldest_iid = (off >= match_off) ? iid : iid - 5'd1;
`else
            rtu_cp0_oldest_iid = 5'd0;
`endif
            #1;
            check({tag, "/busy"}, 64'(cp0_seq_busy), 64'(off >= 1 && off <= lat));
            check({tag, "/zero_when_invalid"}, 64'(junk_on_invalid()), 64'd0);
            if (cp0_csr_rd_vld) begin
                n_rd++;
                check({tag, "/csr_rd_addr"}, 64'(cp0_csr_addr), 64'(imm[11:0]));
                check({tag, "/csr_rd_cycle"}, 64'(off), 64'(lat - 1));
            end
            if (cp0_prf_rd_vld) begin
                n_prf++;
                check({tag, "/prf_rd_preg"}, 64'(cp0_prf_rd_preg), 64'(p1));
                check({tag, "/prf_rd_cycle"}, 64'(off), 64'(lat - 1));
            end
            if (cp0_csr_wr_vld) begin
                n_wr++;
                if (wr_q.size() > 0) begin
                    wre = wr_q.pop_front();
                    check({tag, "/csr_wdata"}, cp0_csr_wdata, wre.wdata);
                    check({tag, "/csr_wr_addr"}, 64'(cp0_csr_addr), 64'(wre.addr));
                    check({tag, "/csr_wr_cycle"}, 64'(off), 64'(wre.lat));
                end
            end
            if (cp0_wb_vld) begin
                n_wb++;
                if (wb_q.size() > 0) begin
                    wbe = wb_q.pop_front();
                    check({tag, "/wb_iid"}, 64'(cp0_wb_iid), 64'(wbe.iid));
                    check({tag, "/wb_data"}, cp0_wb_data, wbe.data);
                    check({tag, "/wb_exc"}, 64'(cp0_wb_exc), 64'(wbe.exc));
                    check({tag, "/wb_cycle"}, 64'(off), 64'(wbe.lat));
                end
            end
        end
        check({tag, "/wb_count"}, 64'(n_wb), 64'd1);
        check({tag, "/wr_count"}, 64'(n_wr), 64'(exp_wr));
        check({tag, "/csr_rd_count"}, 64'(n_rd), 64'(!exp_exc));
        check({tag, "/prf_rd_count"}, 64'(n_prf), 64'(!exp_exc && p1v));
        check({tag, "/wb_q_drained"}, 64'(wb_q.size()), 64'd0);
        check({tag, "/wr_q_drained"}, 64'(wr_q.size()), 64'd0);
        wb_q.delete();
        wr_q.delete();
    endtask

    // Issues a CSRRW and kills it at kill_off with either a flush or a reset.
    task automatic kill_op(input string tag, input bit use_rst, input int kill_off);
        prf_val = 64'h77;
        csr_val = 64'h66;
        for (int off = 0; off <= kill_off + 3; off++) begin
            @(posedge clk); #1;
            cp0_vld = (off == 0);
            cp0_iid = 5'd6; cp0_opcode = 7'h01; cp0_psrc1_vld = 1'b1; cp0_psrc1 = 6'd3;
            cp0_imm_vld = 1'b1; cp0_imm = 64'h300;
`ifdef EXU_CP0_SEQ_SERIALIZE_EN
            rtu_cp0_oldest_iid = 5'd6;
`else
            rtu_cp0_oldest_iid = 5'd0;
`endif
            rtu_global_flush = !use_rst && off == kill_off;
            rst_clk = !(use_rst && off == kill_off);
            #1;
            if (off == kill_off) begin
                if (use_rst)
                    check({tag, "/outputs_in_reset"}, 64'(any_output()), 64'd0);
                else
                    check({tag, "/pulses_in_flush"}, 64'(any_pulse()), 64'd0);
            end else if (off > kill_off) begin
                check({tag, "/busy_after"}, 64'(cp0_seq_busy), 64'd0);
                check({tag, "/pulses_after"}, 64'(any_pulse()), 64'd0);
            end
        end
    endtask

    initial begin
        int exe_off;
        n_chk = 0;
        n_pass = 0;
        prf_val = 64'd0;
        csr_val = 64'd0;
        rst_clk = 1'b0;
        rtu_global_flush = 1'b0;
        cp0_vld = 1'b0;
        cp0_iid = 5'd0;
        cp0_opcode = 7'd0;
        cp0_psrc1_vld = 1'b0;
        cp0_psrc1 = 6'd0;
        cp0_imm_vld = 1'b0;
        cp0_imm = 64'd0;
        rtu_cp0_oldest_iid = 5'd0;
        repeat (3) @(posedge clk);
        #2;
        check("reset/outputs_zero", 64'(any_output()), 64'd0);
        @(posedge clk); #1;
        rst_clk = 1'b1;
        #1;
        check("reset/busy_after_release", 64'(cp0_seq_busy), 64'd0);

        run_op("csrrw_prf", 5'd5, 7'h01, 1'b1, 6'd9, 64'h300, 64'hAA, 64'h11, 1,
               1'b0, 1'b1, 64'hAA, 64'h11, 1'b0);
        run_op("csrrs_zero_imm", 5'd4, 7'h02, 1'b0, 6'd0, 64'h305, 64'h0, 64'h55, 4,
               1'b0, 1'b0, 64'h0, 64'h55, 1'b0);
        run_op("csrrc_hold_vld", 5'd7, 7'h03, 1'b1, 6'd12, 64'h340, 64'h0F, 64'hFF, 1,
               1'b1, 1'b1, 64'hF0, 64'hFF, 1'b0);
        run_op("illegal_op", 5'd2, 7'h7F, 1'b1, 6'd1, 64'h300, 64'h1234, 64'h5678, 1,
               1'b0, 1'b0, 64'h0, 64'h0, 1'b1);
        run_op("csrrs_imm_zext", 5'd9, 7'h02, 1'b0, 6'd0, 64'hFFFF_0000_0001_A7C0, 64'h0, 64'h100, 2,
               1'b0, 1'b1, 64'h11A, 64'h100, 1'b0);
        run_op("csrrc_zero_prf", 5'd31, 7'h03, 1'b1, 6'd63, 64'h7FF, 64'h0, 64'hABCD, 1,
               1'b0, 1'b0, 64'h0, 64'hABCD, 1'b0);
        run_op("csrrw_zero_imm", 5'd0, 7'h01, 1'b0, 6'd0, 64'h001, 64'h0, 64'hC0FFEE, 1,
               1'b0, 1'b1, 64'h0, 64'hC0FFEE, 1'b0);

`ifdef EXU_CP0_SEQ_SERIALIZE_EN
        exe_off = 3;
        kill_op("flush_wait", 1'b0, 1);
`else
        exe_off = 2;
        kill_op("flush_rd", 1'b0, 1);
`endif
        kill_op("flush_exe", 1'b0, exe_off);
        kill_op("flush_with_vld", 1'b0, 0);
        kill_op("reset_exe", 1'b1, exe_off);

        run_op("after_kills", 5'd5, 7'h01, 1'b1, 6'd9, 64'h300, 64'hAA, 64'h11, 1,
               1'b0, 1'b1, 64'hAA, 64'h11, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exu_cp0_seq.md
EXU_CP0_SEQ -- requirements
Module: exu_cp0_seq

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-low; ports named clk and rst_clk.
REQ-002 SHALL have port clk  in  1  core clock; all state changes on rising edge.
REQ-003 SHALL have port rst_clk  in  1  synchronous active-low reset.
REQ-004 SHALL have port rtu_global_flush  in  1  pipeline flush; kills the in-flight op.
REQ-005 SHALL have ports cp0_vld/cp0_iid[4:0]/cp0_opcode[6:0]  in  issued CP0 op, valid/IID/opcode.
REQ-006 SHALL have ports cp0_psrc1_vld/cp0_psrc1[5:0]/cp0_imm_vld/cp0_imm[63:0]  in  issued operands.
REQ-007 SHALL have port rtu_cp0_oldest_iid  in  5  IID of the oldest uncommitted instruction.
REQ-008 SHALL have ports cp0_prf_rd_vld/cp0_prf_rd_preg[5:0]  out  PRF read request; prf_cp0_rdata[63:0]  in  data, one cycle later.
REQ-009 SHALL have ports cp0_csr_rd_vld/cp0_csr_addr[11:0]  out; csr_cp0_rdata[63:0]  in, one cycle later.
REQ-010 SHALL have ports cp0_csr_wr_vld/cp0_csr_wdata[63:0]  out  CSR write, same address.
REQ-011 SHALL have ports cp0_wb_vld/cp0_wb_iid[4:0]/cp0_wb_data[63:0]/cp0_wb_exc  out  writeback.
REQ-012 SHALL have port cp0_seq_busy  out  1  high whenever state != IDLE.

Function
REQ-013 SHALL implement FSM IDLE, WAIT, RD, EXE, one-hot or binary.
REQ-014 IDLE: cp0_vld high and flush low SHALL latch iid, opcode, psrc1_vld, psrc1, imm and go to WAIT.
REQ-015 SHALL ignore cp0_vld while cp0_seq_busy is high; no latch update.
REQ-016 WAIT: SHALL go to RD in the first cycle where rtu_cp0_oldest_iid == latched iid; otherwise stay.
REQ-017 RD (one cycle): SHALL assert cp0_csr_rd_vld with cp0_csr_addr = imm[11:0].
REQ-018 RD: SHALL assert cp0_prf_rd_vld with preg = psrc1 only if psrc1_vld.
REQ-019 EXE (one cycle): operand = psrc1_vld ? prf_cp0_rdata : zero-extended imm[16:12].
REQ-020 SHALL decode opcodes 7'h01 CSRRW (wdata = operand), 7'h02 CSRRS (rdata | operand), 7'h03 CSRRC (rdata & ~operand).
REQ-021 EXE: SHALL assert cp0_csr_wr_vld, except for CSRRS/CSRRC with operand == 0, where it stays low.
REQ-022 EXE: SHALL pulse cp0_wb_vld, cp0_wb_iid = latched iid, cp0_wb_data = csr_cp0_rdata, cp0_wb_exc = 0; then return to IDLE.
REQ-023 Illegal opcode: RD SHALL assert no CSR/PRF read; EXE SHALL assert no CSR write; wb_exc = 1, wb_data = 0.
REQ-024 Minimum latency: accept at T, WAIT match at T+1, RD at T+2, EXE/wb at T+3, IDLE at T+4.
REQ-025 Flush in any state SHALL force IDLE next cycle and suppress csr_rd_vld, prf_rd_vld, csr_wr_vld and wb_vld in the flush cycle.
REQ-026 Flush and cp0_vld in the same cycle: the op SHALL NOT be accepted.
REQ-027 All valid outputs SHALL be single-cycle pulses; data/iid outputs SHALL be zero when their valid is low.

Reset
REQ-028 rst_clk low at a clock edge SHALL force IDLE and clear all latched fields.
REQ-029 While in reset, all outputs SHALL be 0, including cp0_seq_busy.
REQ-030 Reset mid-operation SHALL drop the op with no CSR write and no writeback.

Configuration
REQ-031 Macro EXU_CP0_SEQ_SERIALIZE_EN defined: the WAIT state SHALL behave as in REQ-016.
REQ-032 Macro undefined: WAIT SHALL be bypassed (IDLE->RD directly); rtu_cp0_oldest_iid SHALL be unused; latency is wb at T+2.

Verification
REQ-033 CSRRW iid=5, psrc1_vld=1, imm[11:0]=0x300, prf=0xAA, csr=0x11, oldest=5 -> wr 0xAA at T+3, wb data 0x11 iid 5.
REQ-034 CSRRS imm[16:12]=0, psrc1_vld=0, oldest=3 at T+1 and 4 at T+4 (iid 4) -> RD at T+5; no csr_wr_vld; wb at T+6.
REQ-035 CSRRC operand=0x0F, csr=0xFF -> wdata 0xF0.
REQ-036 Opcode 7'h7F -> no CSR rd/wr, wb_exc=1, wb_data=0.
REQ-037 Flush during EXE, and separately during WAIT -> no wr/wb pulses, busy low next cycle; cp0_vld while busy is ignored.
REQ-038 Rerun REQ-033 with EXU_CP0_SEQ_SERIALIZE_EN undefined and oldest=0 -> wb at T+2.
